graycode_step_sequencer: RTL and testbench
==========================================

// Module: graycode_step_sequencer
// PURPOSE
//   Command-driven sequencer for a WIDTH-bit binary/Gray counter datapath. Accepts
//   "move N steps up/down" commands over a valid/ready handshake and steps an
//   internal binary count once every DWELL clocks. Exposes binary and Gray views,
//   reports busy and signals completion with a one-cycle done pulse.
//   Sits between control logic and any consumer of a Gray-coded position
//   (encoder emulation, FIFO pointer test).
// PARAMETERS
//   WIDTH   3   counter width (bits) of o_bin / o_gray_code; >=2
//   STEP_W  8   width of step-count field i_cmd_steps
//   DWELL   1   clocks between successive steps; >=1
// PORTS
//   clk          in   1       sole clock, rising edge
//   reset        in   1       synchronous, active-high
//   i_cmd_valid  in   1       command present
//   o_cmd_ready  out  1       sequencer can accept a command
//   i_cmd_dir    in   1       1 = count up, 0 = count down
//   i_cmd_steps  in   STEP_W  number of steps to execute (0 allowed)
//   i_abort      in   1       stop the running command early
//   o_busy       out  1       command in progress (state RUN)
//   o_done       out  1       one-cycle pulse: command finished or aborted
//   o_bin        out  WIDTH   current count, binary
//   o_gray_code  out  WIDTH   o_bin ^ (o_bin >> 1)
// BEHAVIOUR
//   - Reset (edge with reset=1): state IDLE; o_bin=0, o_gray_code=0, o_busy=0,
//     o_done=0, o_cmd_ready=1; step and dwell counters cleared. Reset wins over all
//     inputs, including mid-RUN (command discarded, no done pulse).
//   - o_gray_code derives combinationally from registered o_bin (same cycle).
//   - FSM: IDLE -> RUN on accept (valid & ready); RUN -> DONE on last step or abort;
//     DONE -> IDLE unconditionally after 1 cycle.
//   - o_cmd_ready = (state==IDLE); o_busy = (state==RUN); o_done = (state==DONE).
//   - Accept at edge k latches dir and steps N. N=0: go straight to DONE (o_done
//     high in cycle after k), o_bin unchanged.
//   - RUN: dwell counter loads DWELL-1 at accept and decrements; on reaching 0 one step
//     executes and the counter reloads. Steps land at edges k+DWELL, k+2*DWELL, ...;
//     last step at edge k+N*DWELL, same edge enters DONE.
//   - Step arithmetic modulo 2^WIDTH: up from 2^WIDTH-1 wraps to 0; down from 0
//     wraps to 2^WIDTH-1. Every step changes exactly one o_gray_code bit.
//   - Earliest next accept: edge k+N*DWELL+2 (IDLE reached after the DONE cycle).
//   - i_abort sampled only in RUN: edge with i_abort=1 enters DONE and does NOT execute
//     a step due that same edge (abort has priority). Ignored in IDLE/DONE.
//   - i_cmd_valid while not ready is ignored (no queueing); command fields are
//     don't-care when not accepted; latched values are unaffected by later input changes.
//   - o_bin holds its value across commands; never reset except by reset.
// TESTING (WIDTH=3, STEP_W=8, DWELL=1 unless stated)
//   1. reset held 2 cycles, then up, N=5 accepted at edge k -> o_bin 1..5 at edges
//      k+1..k+5; gray 001,011,010,110,111; o_done high only in cycle after k+5.
//   2. From o_bin=0, down, N=3 -> o_bin 7,6,5; gray 100,101,111; single-bit change
//      checked every step; o_cmd_ready low throughout RUN and DONE.
//   3. N=0 command -> o_done pulses next cycle, o_bin unchanged, o_busy never high;
//      second command with valid held during busy accepted only when ready returns.
//   4. Up, N=6 from 0; i_abort=1 on edge where 3rd step is due -> o_bin stops at 2,
//      o_done pulses once, next command accepted 2 cycles later.
//   5. DWELL=3, up N=2 accepted at edge k -> steps at k+3 and k+6 only; o_done in cycle
//      after k+6.
//   6. reset asserted mid-RUN (after 2 of 5 steps) -> next cycle o_bin=0, IDLE,
//      o_busy=0, no o_done pulse; new command runs normally.

Source files
------------

// File: rtl/graycode_step_sequencer.sv
// Command-driven up/down step sequencer for a binary counter with a Gray-coded view.
// One step is taken every DWELL clocks; a one-cycle done pulse closes each command.
`timescale 1ns/1ps
module graycode_step_sequencer #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 8,
    parameter int DWELL  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_dir,
    input  logic [STEP_W-1:0] i_cmd_steps,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_bin,
    output logic [WIDTH-1:0]  o_gray_code
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_RELOAD = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [WIDTH-1:0]  bin_q, bin_d;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Natural modulo-2^WIDTH wrap in both directions.
    function automatic logic [WIDTH-1:0] step_bin(input logic [WIDTH-1:0] b, input logic up);
        return up ? (b + WIDTH'(1)) : (b - WIDTH'(1));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            steps_q <= '0;
            dwell_q <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            steps_q <= steps_d;
            dwell_q <= dwell_d;
            bin_q   <= bin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        steps_d = steps_q;
        dwell_d = dwell_q;
        bin_d   = bin_q;
        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    dir_d   = i_cmd_dir;
                    steps_d = i_cmd_steps;
                    dwell_d = DWELL_RELOAD;
                    state_d = (i_cmd_steps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Abort wins over a step falling due on the same edge.
                if (i_abort) begin
                    state_d = S_DONE;
                end else if (dwell_q == '0) begin
                    bin_d   = step_bin(bin_q, dir_q);
                    steps_d = steps_q - STEP_W'(1);
                    dwell_d = DWELL_RELOAD;
                    if (steps_q == STEP_W'(1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    dwell_d = dwell_q - DW_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_cmd_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q == S_RUN);
    assign o_done      = (state_q == S_DONE);
    assign o_bin       = bin_q;
    assign o_gray_code = to_gray(bin_q);

endmodule

// File: tb/tb_graycode_step_sequencer.sv
// Directed bench for graycode_step_sequencer: a DWELL=1 instance for the main
// command scenarios and a DWELL=3 instance for step spacing.
`timescale 1ns/1ps
module tb_graycode_step_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0, dir = 1'b0, abort = 1'b0;
    logic [7:0] steps = '0;
    logic       ready, busy, done;
    logic [2:0] bin, gray;

    logic       valid3 = 1'b0, dir3 = 1'b0, abort3 = 1'b0;
    logic [7:0] steps3 = '0;
    logic       ready3, busy3, done3;
    logic [2:0] bin3, gray3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    graycode_step_sequencer #(.WIDTH(3), .STEP_W(8), .DWELL(1)) dut (
        .clk(clk), .reset(reset), .i_cmd_valid(valid), .o_cmd_ready(ready),
        .i_cmd_dir(dir), .i_cmd_steps(steps), .i_abort(abort), .o_busy(busy),
        .o_done(done), .o_bin(bin), .o_gray_code(gray)
    );

    graycode_step_sequencer #(.WIDTH(3), .STEP_W(8), .DWELL(3)) dut3 (
        .clk(clk), .reset(reset), .i_cmd_valid(valid3), .o_cmd_ready(ready3),
        .i_cmd_dir(dir3), .i_cmd_steps(steps3), .i_abort(abort3), .o_busy(busy3),
        .o_done(done3), .o_bin(bin3), .o_gray_code(gray3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         up_bin [5]  = '{1, 2, 3, 4, 5};
    int         up_gray[5]  = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
    int         dn_bin [3]  = '{7, 6, 5};
    int         dn_gray[3]  = '{3'b100, 3'b101, 3'b111};
    logic [2:0] prev_gray;

    initial begin
        // Test 1: reset for two cycles, then up N=5
        tick(); tick();
        reset = 1'b0;
        check("rst_bin", bin, 0);
        check("rst_gray", gray, 0);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        valid = 1'b1; dir = 1'b1; steps = 8'd5;
        tick();
        valid = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_bin0", bin, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t1_bin%0d", i + 1), bin, up_bin[i]);
            check($sformatf("t1_gray%0d", i + 1), gray, up_gray[i]);
            check($sformatf("t1_done%0d", i + 1), done, (i == 4) ? 1 : 0);
        end
        tick();
        check("t1_done_clear", done, 0);
        check("t1_ready_back", ready, 1);
        check("t1_bin_hold", bin, 5);

        // Test 2: from 0, down N=3 with wrap
        reset = 1'b1; tick(); reset = 1'b0;
        check("t2_bin_start", bin, 0);
        valid = 1'b1; dir = 1'b0; steps = 8'd3;
        tick();
        valid = 1'b0;
        check("t2_ready_run", ready, 0);
        prev_gray = gray;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t2_bin%0d", i), bin, dn_bin[i]);
            check($sformatf("t2_gray%0d", i), gray, dn_gray[i]);
            check($sformatf("t2_onebit%0d", i), $countones(gray ^ prev_gray), 1);
            check($sformatf("t2_ready%0d", i), ready, 0);
            prev_gray = gray;
        end
        check("t2_done", done, 1);
        tick();
        check("t2_ready_back", ready, 1);

        // Test 3: N=0 command, then a command held valid across busy periods
        valid = 1'b1; dir = 1'b1; steps = 8'd0;
        tick();
        check("t3_zero_done", done, 1);
        check("t3_zero_busy", busy, 0);
        check("t3_zero_bin", bin, 5);
        check("t3_zero_ready", ready, 0);
        steps = 8'd2;
        tick();
        check("t3_not_taken_busy", busy, 0);
        check("t3_ready_idle", ready, 1);
        check("t3_done_clear", done, 0);
        tick();
        check("t3_accept_busy", busy, 1);
        dir = 1'b0; steps = 8'd1;
        tick();
        check("t3_latched_dir", bin, 6);
        tick();
        check("t3_latched_n", bin, 7);
        check("t3_done2", done, 1);
        tick();
        check("t3_ready3", ready, 1);
        tick();
        valid = 1'b0;
        check("t3_busy3", busy, 1);
        tick();
        check("t3_bin3", bin, 6);
        check("t3_done3", done, 1);
        tick();

        // Test 4: abort on the edge where the third step is due
        reset = 1'b1; tick(); reset = 1'b0;
        valid = 1'b1; dir = 1'b1; steps = 8'd6;
        tick();
        valid = 1'b0;
        tick();
        check("t4_bin1", bin, 1);
        tick();
        check("t4_bin2", bin, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_bin", bin, 2);
        check("t4_abort_done", done, 1);
        check("t4_abort_busy", busy, 0);
        valid = 1'b1; dir = 1'b1; steps = 8'd1;
        tick();
        check("t4_single_pulse", done, 0);
        check("t4_not_yet", busy, 0);
        tick();
        valid = 1'b0;
        check("t4_accept", busy, 1);
        tick();
        check("t4_bin3", bin, 3);
        tick();

        // Test 6: reset during RUN after two of five steps
        valid = 1'b1; dir = 1'b1; steps = 8'd5;
        tick();
        valid = 1'b0;
        tick(); tick();
        check("t6_bin_mid", bin, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_bin_rst", bin, 0);
        check("t6_busy_rst", busy, 0);
        check("t6_ready_rst", ready, 1);
        check("t6_done_rst", done, 0);
        tick();
        check("t6_no_done", done, 0);
        valid = 1'b1; dir = 1'b1; steps = 8'd2;
        tick();
        valid = 1'b0;
        tick();
        check("t6_new_bin1", bin, 1);
        tick();
        check("t6_new_bin2", bin, 2);
        check("t6_new_done", done, 1);
        tick();

        // Test 5: DWELL=3, up N=2
        check("t5_start", bin3, 0);
        valid3 = 1'b1; dir3 = 1'b1; steps3 = 8'd2;
        tick();
        valid3 = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            check($sformatf("t5_bin_t%0d", t), bin3, (t < 3) ? 0 : (t < 6) ? 1 : 2);
            check($sformatf("t5_done_t%0d", t), done3, (t == 6) ? 1 : 0);
            check($sformatf("t5_busy_t%0d", t), busy3, (t < 6) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
